// File: rtl/sum_disp_pkg.sv
// sum_disp_pkg: shared types and constants for the sum BCD display stage.
//   state_t      - conversion FSM states
//   SEG_*        - active-low {g,f,e,d,c,b,a} segment patterns
//   add3_nibble  - double-dabble correction step for one BCD nibble
package sum_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // A nibble of 5 or more would exceed 9 after the next left shift, so it is
  // pre-corrected by 3 to carry cleanly into the next decimal digit.
  function automatic logic [3:0] add3_nibble(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational BCD digit to active-low seven-segment pattern.
//   digit_i  - BCD digit (values above 9 decode to blank)
//   blank_i  - force all segments off
//   seg_o    - {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_decoder
  import sum_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_bcd_display.sv
// sum_bcd_display: accepts the adder's binary sum over valid/ready, converts
// it to BCD one bit per clock (shift-add-3), and latches the decimal digits
// plus their active-low seven-segment patterns.
//   CLOCK_50   - system clock
//   resetn     - synchronous active-low reset
//   sum_in     - binary sum, sampled when sum_valid && ready
//   sum_valid  - request a conversion
//   ready      - idle, will accept sum_valid this cycle
//   done       - one-cycle pulse when bcd_out/hex_out update
//   bcd_out    - latched BCD digits, digit 0 in [3:0]
//   hex_out    - latched segment patterns, digit 0 in [6:0]
//
// state | meaning
// IDLE  | waiting for sum_valid; ready high
// CONV  | one correct-and-shift step per cycle, counter counts down to 0
// LOAD  | latch digits and segments, pulse done
module sum_bcd_display
  import sum_disp_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int DIGITS   = 2,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic [WIDTH-1:0]      sum_in,
  input  logic                  sum_valid,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int SW = WIDTH + 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                state_q;
  logic [SW-1:0]         scratch_q, scratch_d;
  logic [CW-1:0]         cnt_q;
  logic                  ready_q, done_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [7*DIGITS-1:0]   hex_q, hex_d;
  logic [4*DIGITS-1:0]   bcd_res;
  logic [DIGITS-1:0]     blank;
  logic                  upper_zero;

  // Correct every BCD nibble, then shift the whole register left by one.
  always_comb begin
    logic [SW-1:0] adj;
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      adj[WIDTH + 4*i +: 4] = add3_nibble(scratch_q[WIDTH + 4*i +: 4]);
    end
    scratch_d = {adj[SW-2:0], 1'b0};
  end

  // After the last shift the BCD digits sit above the binary field.
  assign bcd_res = scratch_q[SW-1 -: 4*DIGITS];

  // A digit above 0 is blanked only if it and every digit above it are zero.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (bcd_res[4*i +: 4] == 4'd0);
      blank[i]   = BLANK_LZ && upper_zero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .digit_i (bcd_res[4*g +: 4]),
      .blank_i (blank[g]),
      .seg_o   (hex_d[7*g +: 7])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      hex_q     <= '1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sum_valid) begin
            scratch_q <= {{(4*DIGITS){1'b0}}, sum_in};
            cnt_q     <= CW'(WIDTH - 1);
            ready_q   <= 1'b0;
            state_q   <= CONV;
          end
        end
        CONV: begin
          scratch_q <= scratch_d;
          if (cnt_q == '0) state_q <= LOAD;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        LOAD: begin
          bcd_q   <= bcd_res;
          hex_q   <= hex_d;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign hex_out = hex_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
module tb_sum_bcd_display;

  localparam int WIDTH  = 5;
  localparam int DIGITS = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  sum_in = '0;
  logic        sum_valid = 1'b0;
  logic        ready, done;
  logic [7:0]  bcd_out;
  logic [13:0] hex_out;

  sum_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .sum_in    (sum_in),
    .sum_valid (sum_valid),
    .ready     (ready),
    .done      (done),
    .bcd_out   (bcd_out),
    .hex_out   (hex_out)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  sum;
    logic [7:0]  bcd;
    logic [13:0] hex;
  } vec_t;

  typedef struct {
    logic [7:0]  bcd;
    logic [13:0] hex;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] hex_ref(input int v);
    int t;
    int o;
    t = v / 10;
    o = v % 10;
    return {(t == 0) ? 7'b1111111 : seg_ref(t), seg_ref(o)};
  endfunction

  function automatic logic [7:0] bcd_ref(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: push expected at acceptance, pop and compare on done.
  logic        mon_en = 1'b0;
  logic        chk_low = 1'b0;
  logic        b2b = 1'b0;
  int          last_acc = -1;
  logic [7:0]  last_bcd = '0;
  logic [13:0] last_hex = '1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_low) chk("done_one_cycle", 32'(done), 32'd0);
      chk_low = 1'b0;
      if (done) begin
        chk_low = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with bcd %0h, expected no output", bcd_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bcd", 32'(bcd_out), 32'(mon_e.bcd));
          chk("hex", 32'(hex_out), 32'(mon_e.hex));
          chk("latency", 32'(cyc - mon_e.acc), 32'(WIDTH + 1));
        end
        last_bcd = bcd_out;
        last_hex = hex_out;
      end else begin
        chk("hold_bcd", 32'(bcd_out), 32'(last_bcd));
        chk("hold_hex", 32'(hex_out), 32'(last_hex));
      end
      if (!resetn) begin
        exp_q.delete();
        last_bcd = '0;
        last_hex = '1;
        chk_low  = 1'b0;
      end else if (sum_valid && ready) begin
        mon_e.bcd = bcd_ref(int'(sum_in));
        mon_e.hex = hex_ref(int'(sum_in));
        mon_e.acc = cyc + 1;
        exp_q.push_back(mon_e);
        if (b2b && last_acc >= 0) chk("b2b_spacing", 32'(mon_e.acc - last_acc), 32'(WIDTH + 2));
        last_acc = mon_e.acc;
      end
    end
  end

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !ready) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no result within %0d cycles, expected done", budget);
      exp_q.delete();
    end
  endtask

  task automatic send(input logic [4:0] v);
    sum_in    = v;
    sum_valid = 1'b1;
    @(posedge clk);
    #1;
    sum_valid = 1'b0;
    wait_quiet(20);
  endtask

  initial begin
    vec_t tbl[7];
    int   seq[2];
    int   k;
    int   n;
    logic rdy;

    tbl[0] = '{5'd31, 8'h31, 14'b0110000_1111001};
    tbl[1] = '{5'd0,  8'h00, 14'b1111111_1000000};
    tbl[2] = '{5'd9,  8'h09, 14'b1111111_0010000};
    tbl[3] = '{5'd19, 8'h19, 14'b1111001_0010000};
    tbl[4] = '{5'd10, 8'h10, 14'b1111001_1000000};
    tbl[5] = '{5'd25, 8'h25, 14'b0100100_0010010};
    tbl[6] = '{5'd7,  8'h07, 14'b1111111_1111000};
    seq[0] = 10;
    seq[1] = 25;

    // Reset
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_bcd",   32'(bcd_out), 32'h00);
    chk("rst_hex",   32'(hex_out), 32'h3FFF);
    resetn = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed table vectors
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].sum);
      chk($sformatf("tbl_bcd_%0d", tbl[i].sum), 32'(bcd_out), 32'(tbl[i].bcd));
      chk($sformatf("tbl_hex_%0d", tbl[i].sum), 32'(hex_out), 32'(tbl[i].hex));
    end

    // Back-to-back with sum_valid held high; junk value while busy
    b2b = 1'b1;
    last_acc = -1;
    k = 0;
    n = 0;
    sum_valid = 1'b1;
    while (k < 4 && n < 100) begin
      rdy = ready;
      sum_in = rdy ? 5'(seq[k % 2]) : 5'd30;
      @(posedge clk);
      #1;
      n++;
      if (rdy) k++;
    end
    sum_valid = 1'b0;
    b2b = 1'b0;
    chk("b2b_accepts", 32'(k), 32'd4);
    wait_quiet(30);
    chk("b2b_last_bcd", 32'(bcd_out), 32'(tbl[5].bcd));
    chk("b2b_last_hex", 32'(hex_out), 32'(tbl[5].hex));

    // Reset at the third CONV edge of a 22 conversion
    sum_in    = 5'd22;
    sum_valid = 1'b1;
    @(posedge clk);
    #1;
    sum_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done",  32'(done), 32'd0);
    chk("abort_bcd",   32'(bcd_out), 32'h00);
    chk("abort_hex",   32'(hex_out), 32'h3FFF);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    send(tbl[6].sum);
    chk("post_abort_bcd", 32'(bcd_out), 32'(tbl[6].bcd));
    chk("post_abort_hex", 32'(hex_out), 32'(tbl[6].hex));

    // Exhaustive sweep against the divide/modulo model
    for (int v = 0; v < 32; v++) send(5'(v));

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_bcd_display.md
# sum_bcd_display

Downstream display stage for the 4-bit switch adder. Takes the 5-bit sum (carry plus 4 sum bits) through a valid/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock. It latches the decimal digits and drives active-low seven-segment patterns for the board's HEX displays, so the sum reads in decimal next to the raw binary on LEDR.

## Interface
- WIDTH, 5: binary input width (adder carry + 4 sum bits).
- DIGITS, 2: BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH − 1.
- BLANK_LZ, 1: 1 = blank leading-zero digits above digit 0.

- CLOCK_50  input  1  system clock, all state on rising edge.
- resetn  input  1  synchronous, active-low reset.
- sum_in  input  WIDTH  binary sum from the adder (LEDR[4:0] bus).
- sum_valid  input  1  sum_in is to be converted; sampled only when ready=1.
- ready  output  1  engine idle, will accept sum_valid this cycle.
- done  output  1  one-cycle pulse, bcd_out/hex_out just updated.
- bcd_out  output  4*DIGITS  latched BCD result, digit 0 in bits [3:0].
- hex_out  output  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit, digit 0 in bits [6:0] (maps to HEX0).

## Operation
- FSM states: IDLE, CONV, LOAD.
- IDLE: ready=1. On sum_valid=1, capture sum_in into the binary part of a scratch register (WIDTH + 4*DIGITS bits, BCD part zeroed), load the bit counter with WIDTH−1, go to CONV.
- CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift the whole scratch register left by one. When the counter is 0, go to LOAD. Otherwise decrement.
- LOAD: copy the BCD nibbles to bcd_out, update hex_out, pulse done, return to IDLE.
- Segment map (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles >9 cannot occur; decode them to blank (1111111).
- Blanking: with BLANK_LZ=1, a digit i>0 is blanked when it and all digits above it are zero. Digit 0 is never blanked.
- sum_valid while ready=0 is ignored. No queuing, no error flag.
- Reset values: ready=1, done=0, bcd_out=0, hex_out all ones (all segments off), state IDLE, scratch and counter 0.
- resetn low mid-conversion aborts it. Outputs take their reset values at that edge, and the partial result is discarded.

## Timing
- Accept at edge N (sum_valid=1, ready=1). ready=0 from N through N+WIDTH.
- Shift steps at edges N+1 … N+WIDTH. LOAD state occupies the cycle after edge N+WIDTH.
- bcd_out, hex_out, done=1 and ready=1 all appear after edge N+WIDTH+1. Latency is WIDTH+1 cycles, 6 at default.
- done falls at edge N+WIDTH+2.
- Back-to-back: a sum_valid present in the done cycle is accepted at edge N+WIDTH+2. Sustained throughput is one conversion per WIDTH+2 cycles.
- bcd_out and hex_out hold their values between LOAD edges.

## Structure
- Package sum_disp_pkg holds:
  - state enum {IDLE, CONV, LOAD}
  - SEG_BLANK = 7'h7F
  - the ten digit segment constants
  - function add3_nibble
- Sub-module seg7_decoder: combinational 4-bit → 7-bit active-low decoder with a blank input. Instantiate it once per digit with a generate loop.
- Keep the conversion datapath in the top module. Do not write a separate instance for a fixed case like the 2-digit one.

## Test plan
- Reset: hold resetn=0 for 3 cycles → ready=1, done=0, bcd_out=0, hex_out=14'h3FFF.
- sum_in=31 (15+15+carry) with valid → 6 cycles later: bcd_out=8'h31, hex_out={0110000,1111001}, done high exactly one cycle.
- sum_in=0 → bcd_out=8'h00, hex_out={1111111,1000000}. Also sum_in=9 → tens blank, HEX0=0010000. Also sum_in=19 → {1111001,0010000}.
- sum_valid held high continuously with sum_in cycling 10, 25 → accept one value every 7 cycles; results 8'h10 then 8'h25 in order; valid pulses during busy cause no output change.
- resetn=0 for one cycle at the third CONV edge of a sum_in=22 conversion → no done pulse, outputs at reset values, next accepted sum_in=7 converts to 8'h07 correctly.
- Exhaustive sweep 0–31 compared against a reference divide/modulo model, with latency checked at 6 cycles for every value.
